// File: rtl/instr_mem_responder.sv
// instr_mem_responder: preloadable instruction memory answering PC fetches after LATENCY cycles over valid/ready
module instr_mem_responder #(
  parameter int ADDR_W  = 4,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [15:0]       req_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_instr,
  output logic              rsp_err,
  output logic              busy,
  output logic [15:0]       fetch_count
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_d;
  logic [15:0] mem [DEPTH];
  logic [2:0] cnt;
  logic [ADDR_W-1:0] word;
  logic err, accept;
  assign word = req_pc[ADDR_W:1];
  assign err = req_pc[0] | (|(req_pc >> (ADDR_W + 1)));
  assign req_ready = (state == IDLE) & ~load_en;
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  always_comb begin
    state_d = state;
    accept = 1'b0;
    case (state)
      IDLE: begin
        accept = req_valid & ~load_en;
        state_d = accept ? ((LATENCY == 1) ? RESP : WAIT) : IDLE;
      end
      WAIT: state_d = (cnt == 3'd0) ? RESP : WAIT;
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 3'd0;
      rsp_instr <= 16'h0000;
      rsp_err <= 1'b0;
      fetch_count <= 16'h0000;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 16'h0000;
    end else begin
      state <= state_d;
      if (load_en) mem[load_addr] <= load_data;
      if (accept) begin
        rsp_instr <= err ? 16'h0000 : mem[word];
        rsp_err <= err;
        cnt <= 3'(LATENCY - 1);
      end else if (state == WAIT && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (state == RESP && rsp_ready) fetch_count <= fetch_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: scoreboard bench driving LATENCY=1 and LATENCY=3 responders in lockstep
module tb_instr_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, load_en = 1'b0, req_valid = 1'b0, rsp_ready = 1'b1;
  logic [3:0] load_addr = '0;
  logic [15:0] load_data = '0, req_pc = '0;
  logic a_req_ready, a_rsp_valid, a_rsp_err, a_busy;
  logic b_req_ready, b_rsp_valid, b_rsp_err, b_busy;
  logic [15:0] a_rsp_instr, a_fetch_count, b_rsp_instr, b_fetch_count;
  int checks = 0, passes = 0;
  logic [16:0] qa[$], qb[$];
  instr_mem_responder #(.ADDR_W(4), .LATENCY(1)) u_a (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .req_valid(req_valid), .req_ready(a_req_ready), .req_pc(req_pc), .rsp_valid(a_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_instr(a_rsp_instr), .rsp_err(a_rsp_err), .busy(a_busy),
    .fetch_count(a_fetch_count));
  instr_mem_responder #(.ADDR_W(4), .LATENCY(3)) u_b (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_pc(req_pc), .rsp_valid(b_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_instr(b_rsp_instr), .rsp_err(b_rsp_err), .busy(b_busy),
    .fetch_count(b_fetch_count));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  initial forever begin
    @(negedge clk);
    if (!rst && rsp_ready && a_rsp_valid) begin
      if (qa.size() == 0) chk("a_rsp_unexpected", 32'(qa.size()), 1);
      else chk("a_rsp", {15'd0, a_rsp_err, a_rsp_instr}, {15'd0, qa.pop_front()});
    end
    if (!rst && rsp_ready && b_rsp_valid) begin
      if (qb.size() == 0) chk("b_rsp_unexpected", 32'(qb.size()), 1);
      else chk("b_rsp", {15'd0, b_rsp_err, b_rsp_instr}, {15'd0, qb.pop_front()});
    end
  end
  task automatic ld(input logic [3:0] a, input logic [15:0] d);
    @(posedge clk); #1 load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1 load_en = 1'b0;
  endtask
  task automatic issue(input logic [15:0] pc, input logic [16:0] e);
    bit ok = 0;
    qa.push_back(e);
    qb.push_back(e);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk); #1;
      ok = a_req_ready && b_req_ready;
    end
    if (!ok) chk("issue_ready_timeout", {30'd0, a_req_ready, b_req_ready}, 2'b11);
    req_valid = 1'b1; req_pc = pc;
    @(posedge clk); #1 req_valid = 1'b0;
  endtask
  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = !a_busy && !b_busy;
    end
    if (!ok) chk("idle_timeout", {30'd0, a_busy, b_busy}, 0);
  endtask
  task automatic chk_reset_state();
    chk("rst_req_ready", {a_req_ready, b_req_ready}, 2'b11);
    chk("rst_rsp_valid", {a_rsp_valid, b_rsp_valid}, 0);
    chk("rst_busy", {a_busy, b_busy}, 0);
    chk("rst_count", {a_fetch_count, b_fetch_count}, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state();
    chk("rst_instr_err", {a_rsp_err, b_rsp_err, a_rsp_instr, b_rsp_instr}, 0);
    ld(4'd0, 16'h0400);
    ld(4'd1, 16'h0441);
    ld(4'd2, 16'h2050);
    issue(16'h0000, {1'b0, 16'h0400});
    issue(16'h0002, {1'b0, 16'h0441});
    issue(16'h0004, {1'b0, 16'h2050});
    wait_idle();
    chk("count_after_3", {a_fetch_count, b_fetch_count}, {16'd3, 16'd3});
    @(posedge clk); #1 rsp_ready = 1'b0;
    issue(16'h0002, {1'b0, 16'h0441});
    for (int i = 0; i < 20 && !b_rsp_valid; i++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", {a_rsp_valid, b_rsp_valid}, 2'b11);
      chk("stall_instr", {a_rsp_instr, b_rsp_instr}, {16'h0441, 16'h0441});
      chk("stall_req_ready", {a_req_ready, b_req_ready}, 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_idle();
    chk("count_after_stall", {a_fetch_count, b_fetch_count}, {16'd4, 16'd4});
    issue(16'h0003, {1'b1, 16'h0000});
    issue(16'h0020, {1'b1, 16'h0000});
    wait_idle();
    chk("count_after_err", {a_fetch_count, b_fetch_count}, {16'd6, 16'd6});
    issue(16'h0004, {1'b0, 16'h2050});
    @(negedge clk);
    chk("lat_edge_n", {a_rsp_valid, b_rsp_valid}, 2'b10);
    @(negedge clk);
    chk("lat3_edge_n1", {31'd0, b_rsp_valid}, 0);
    @(negedge clk);
    chk("lat3_edge_n2", {31'd0, b_rsp_valid}, 0);
    @(negedge clk);
    chk("lat3_edge_n3", {31'd0, b_rsp_valid}, 1);
    wait_idle();
    issue(16'h0000, {1'b0, 16'h0400});
    @(posedge clk); #1;
    chk("b_in_wait", {31'd0, b_busy && !b_rsp_valid}, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    qb.delete();
    @(negedge clk);
    chk_reset_state();
    issue(16'h0000, {1'b0, 16'h0000});
    issue(16'h0002, {1'b0, 16'h0000});
    wait_idle();
    @(posedge clk); #1 load_en = 1'b1; load_addr = 4'd1; load_data = 16'h0441;
    req_valid = 1'b1; req_pc = 16'h0000;
    @(negedge clk);
    chk("load_blocks_ready", {a_req_ready, b_req_ready}, 0);
    @(posedge clk); #1 load_en = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("load_no_accept", {a_busy, b_busy}, 0);
    issue(16'h0002, {1'b0, 16'h0441});
    load_en = 1'b1; load_addr = 4'd1; load_data = 16'hB041;
    @(posedge clk); #1 load_en = 1'b0;
    wait_idle();
    issue(16'h0002, {1'b0, 16'hB041});
    wait_idle();
    chk("count_final", {a_fetch_count, b_fetch_count}, {16'd4, 16'd4});
    chk("queues_drained", 32'(qa.size() + qb.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
